// File: rtl/pc_unit.sv
// Program-counter unit: architectural PC, next-PC target selection, and a
// circular return-address stack with a saturating jr $ra mispredict counter.
module pc_unit #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
    parameter int unsigned RAS_DEPTH  = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  br_take_i,
    input  logic [15:0]           br_off_i,
    input  logic                  j_take_i,
    input  logic [25:0]           j_index_i,
    input  logic                  jal_i,
    input  logic                  jr_take_i,
    input  logic [ADDR_WIDTH-1:0] jr_target_i,
    input  logic                  jr_ra_i,
    input  logic                  exc_i,
    input  logic                  eret_i,
    input  logic [ADDR_WIDTH-1:0] epc_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] link_o,
    output logic [ADDR_WIDTH-1:0] ras_top_o,
    output logic                  ras_valid_o,
    output logic [CNT_WIDTH-1:0]  mispred_cnt_o
);
    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    addr_t               pc_q, pc_d;
    addr_t               seq, br_tgt, j_tgt, top;
    addr_t               ras_q [RAS_DEPTH];
    logic [PW-1:0]       ptr_q, ptr_d, top_idx;
    logic [PW:0]         occ_q, occ_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                push, pop, empty, miss;

    assign seq    = pc_q + ADDR_WIDTH'(4);
    assign br_tgt = seq + {{(ADDR_WIDTH-18){br_off_i[15]}}, br_off_i, 2'b00};

    // A 28-bit PC has no region bits above the instr_index field.
    generate
        if (ADDR_WIDTH > 28) begin : g_jregion
            assign j_tgt = {seq[ADDR_WIDTH-1:28], j_index_i, 2'b00};
        end else begin : g_jflat
            assign j_tgt = {j_index_i, 2'b00};
        end
    endgenerate

    assign empty   = (occ_q == '0);
    assign top_idx = ptr_q - PW'(1);
    assign top     = empty ? '0 : ras_q[top_idx];

    // jalr $31 sets both jal_i and jr_ra_i; it counts only as a push.
    assign push = jal_i & (j_take_i | jr_take_i) & ~stall_i & ~exc_i;
    assign pop  = jr_take_i & jr_ra_i & ~jal_i & ~stall_i & ~exc_i;
    assign miss = pop & (empty | (jr_target_i != top));

    always_comb begin
        pc_d = seq;
        if (exc_i)          pc_d = EXC_VECTOR[ADDR_WIDTH-1:0];
        else if (stall_i)   pc_d = pc_q;
        else if (eret_i)    pc_d = epc_i;
        else if (jr_take_i) pc_d = jr_target_i;
        else if (j_take_i)  pc_d = j_tgt;
        else if (br_take_i) pc_d = br_tgt;
    end

    always_comb begin
        ptr_d = ptr_q;
        occ_d = occ_q;
        if (push) begin
            ptr_d = ptr_q + PW'(1);
            if (occ_q != FULL) occ_d = occ_q + (PW+1)'(1);
        end else if (pop && !empty) begin
            ptr_d = top_idx;
            occ_d = occ_q - (PW+1)'(1);
        end
    end

    assign cnt_d = (miss && (cnt_q != '1)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC[ADDR_WIDTH-1:0];
            ptr_q <= '0;
            occ_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            occ_q <= occ_d;
            cnt_q <= cnt_d;
            if (push) ras_q[ptr_q] <= seq;
        end
    end

    assign pc_o          = pc_q;
    assign link_o        = seq;
    assign ras_top_o     = top;
    assign ras_valid_o   = ~empty;
    assign mispred_cnt_o = cnt_q;
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: a queue-based reference model checked every cycle against
// a 32-bit instance and a 28-bit / 2-bit-counter instance, plus directed pins.
module tb_pc_unit;
    logic        clk = 1'b0;
    logic        rst, stall, br_take, j_take, jal, jr_take, jr_ra, exc, eret;
    logic [15:0] br_off;
    logic [25:0] j_index;
    logic [31:0] jr_target, epc;

    logic [31:0] pc_a, link_a, top_a;
    logic        valid_a;
    logic [15:0] cnt_a;
    logic [27:0] pc_b, link_b, top_b;
    logic        valid_b;
    logic [1:0]  cnt_b;

    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    pc_unit dut_a (
        .clk(clk), .rst(rst), .stall_i(stall), .br_take_i(br_take), .br_off_i(br_off),
        .j_take_i(j_take), .j_index_i(j_index), .jal_i(jal), .jr_take_i(jr_take),
        .jr_target_i(jr_target), .jr_ra_i(jr_ra), .exc_i(exc), .eret_i(eret), .epc_i(epc),
        .pc_o(pc_a), .link_o(link_a), .ras_top_o(top_a), .ras_valid_o(valid_a),
        .mispred_cnt_o(cnt_a)
    );

    pc_unit #(.ADDR_WIDTH(28), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .stall_i(stall), .br_take_i(br_take), .br_off_i(br_off),
        .j_take_i(j_take), .j_index_i(j_index), .jal_i(jal), .jr_take_i(jr_take),
        .jr_target_i(jr_target[27:0]), .jr_ra_i(jr_ra), .exc_i(exc), .eret_i(eret),
        .epc_i(epc[27:0]), .pc_o(pc_b), .link_o(link_b), .ras_top_o(top_b),
        .ras_valid_o(valid_b), .mispred_cnt_o(cnt_b)
    );

    // Reference model: RAS as a bounded queue, newest at the back.
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    int          m_cnt;
    bit          m_init = 0;

    function automatic logic [31:0] m_top();
        return (m_ras.size() == 0) ? 32'h0 : m_ras[m_ras.size()-1];
    endfunction

    always @(posedge clk) begin
        logic [31:0] s, nxt;
        if (rst) begin
            m_pc = 32'h0; m_ras.delete(); m_cnt = 0; m_init = 1;
        end else begin
            s = m_pc + 32'd4;
            if (!stall && !exc && jal && (j_take || jr_take)) begin
                m_ras.push_back(s);
                if (m_ras.size() > 4) void'(m_ras.pop_front());
            end else if (!stall && !exc && jr_take && jr_ra && !jal) begin
                if (m_ras.size() == 0 || jr_target != m_top()) m_cnt++;
                if (m_ras.size() != 0) void'(m_ras.pop_back());
            end
            if (exc)          nxt = 32'h180;
            else if (stall)   nxt = m_pc;
            else if (eret)    nxt = epc;
            else if (jr_take) nxt = jr_target;
            else if (j_take)  nxt = {s[31:28], j_index, 2'b00};
            else if (br_take) nxt = s + {{14{br_off[15]}}, br_off, 2'b00};
            else              nxt = s;
            m_pc = nxt;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            chk("pc_a",    pc_a, m_pc);
            chk("link_a",  link_a, m_pc + 32'd4);
            chk("top_a",   top_a, m_top());
            chk("valid_a", {31'b0, valid_a}, {31'b0, m_ras.size() != 0});
            chk("cnt_a",   {16'b0, cnt_a}, (m_cnt > 65535) ? 32'hFFFF : m_cnt);
            chk("pc_b",    {4'b0, pc_b}, {4'b0, m_pc[27:0]});
            chk("link_b",  {4'b0, link_b}, {4'b0, m_pc[27:0] + 28'd4});
            chk("top_b",   {4'b0, top_b}, {4'b0, m_top()[27:0]});
            chk("valid_b", {31'b0, valid_b}, {31'b0, m_ras.size() != 0});
            chk("cnt_b",   {30'b0, cnt_b}, (m_cnt > 3) ? 32'd3 : m_cnt);
        end
    end

    task automatic clr();
        stall = 0; br_take = 0; j_take = 0; jal = 0; jr_take = 0; jr_ra = 0;
        exc = 0; eret = 0; br_off = 0; j_index = 0; jr_target = 0; epc = 0;
    endtask

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic do_jr(input logic [31:0] t, input logic ra);
        clr(); jr_take = 1; jr_ra = ra; jr_target = t; tick();
    endtask

    task automatic do_jal(input logic [25:0] idx);
        clr(); j_take = 1; jal = 1; j_index = idx; tick();
    endtask

    logic [31:0] links [4];

    initial begin
        clr(); rst = 1; exc = 1; j_take = 1; j_index = 26'h3FF;
        tick(); tick();
        chk("rst_pc", pc_a, 32'h0);
        chk("rst_valid", {31'b0, valid_a}, 32'h0);
        chk("rst_cnt", {16'b0, cnt_a}, 32'h0);
        rst = 0; clr();
        chk("seq0", pc_a, 32'h0);
        tick(); chk("seq4", pc_a, 32'h4);
        tick(); chk("seq8", pc_a, 32'h8);
        tick(); chk("seq12", pc_a, 32'hC);

        do_jr(32'h100, 0); chk("jr_100", pc_a, 32'h100);
        clr(); br_take = 1; br_off = 16'hFFFE; tick();
        chk("br_neg", pc_a, 32'hFC);
        do_jr(32'hFFFF_FFFC, 0);
        clr(); tick(); chk("wrap", pc_a, 32'h0);

        do_jr(32'h4000_0010, 0);
        do_jal(26'h40);
        chk("jal_pc", pc_a, 32'h4000_0100);
        chk("jal_top", top_a, 32'h4000_0014);
        clr(); tick();
        do_jr(32'h4000_0014, 1);
        chk("ret_pc", pc_a, 32'h4000_0014);
        chk("ret_valid", {31'b0, valid_a}, 32'h0);
        chk("ret_cnt", {16'b0, cnt_a}, 32'h0);

        // Five pushes into a depth-4 stack: link A is overwritten.
        for (int k = 1; k <= 5; k++) do_jal(26'(k * 32'h100));
        links = '{32'h4000_1004, 32'h4000_0C04, 32'h4000_0804, 32'h4000_0404};
        for (int k = 0; k < 4; k++) begin
            chk("ovf_top", top_a, links[k]);
            do_jr(links[k], 1);
        end
        chk("ovf_empty", {31'b0, valid_a}, 32'h0);
        do_jr(32'h1234, 1);
        chk("pop_empty_cnt", {16'b0, cnt_a}, 32'h1);
        chk("pop_empty_valid", {31'b0, valid_a}, 32'h0);

        do_jal(26'h10);
        chk("push_top", top_a, 32'h1238);
        clr(); stall = 1; exc = 1; eret = 1; epc = 32'h2000; jr_take = 1; jal = 1;
        jr_ra = 1; jr_target = 32'h3000; br_take = 1; br_off = 16'h8;
        tick();
        chk("exc_stall_pc", pc_a, 32'h180);
        chk("exc_stall_top", top_a, 32'h1238);
        clr(); stall = 1; br_take = 1; j_take = 1; jal = 1;
        for (int k = 0; k < 3; k++) begin
            tick(); chk("stall_hold", pc_a, 32'h180);
        end
        clr(); eret = 1; epc = 32'h2000; jr_take = 1; jr_target = 32'h3000; j_take = 1;
        tick(); chk("eret_over_jr", pc_a, 32'h2000);
        clr(); jr_take = 1; jr_target = 32'h3000; j_take = 1; j_index = 26'h20; br_take = 1;
        tick(); chk("jr_over_j", pc_a, 32'h3000);
        clr(); j_take = 1; j_index = 26'h20; br_take = 1; br_off = 16'h4;
        tick(); chk("j_over_br", pc_a, 32'h80);

        clr(); rst = 1; tick(); rst = 0;
        do_jal(26'h10);
        for (int k = 1; k <= 5; k++) begin
            do_jr(32'h500, 1);
            chk("sat_b", {30'b0, cnt_b}, (k > 3) ? 32'd3 : 32'(k));
            chk("cnt_a_grow", {16'b0, cnt_a}, 32'(k));
        end

        clr(); jal = 1; jr_take = 1; jr_ra = 1; jr_target = 32'h300; tick();
        chk("jalr_pc", pc_a, 32'h300);
        chk("jalr_top", top_a, 32'h504);
        chk("jalr_cnt", {16'b0, cnt_a}, 32'h5);
        clr(); tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit: the architectural PC register plus full next-PC selection.
- Selects between sequential, branch, jump, jump-register, exception-vector and ERET targets.
- Contains a circular return-address stack (RAS) that predicts jr $ra targets, plus a saturating RAS-mispredict counter.
- Sits at the front of the fetch stage. Drives the instruction-memory address and supplies the link address to the register file.

Parameters:
ADDR_WIDTH, 32, PC width in bits; legal range 28..32
RESET_PC, 32'h0000_0000, PC value loaded on reset (low ADDR_WIDTH bits used)
EXC_VECTOR, 32'h0000_0180, exception entry address (low ADDR_WIDTH bits used)
RAS_DEPTH, 4, number of RAS entries; power of two, 2..16
CNT_WIDTH, 16, width of the mispredict counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
stall_i  input  1  hold PC and RAS this cycle
br_take_i  input  1  conditional branch resolved taken
br_off_i  input  16  branch immediate (signed word offset)
j_take_i  input  1  j/jal taken
j_index_i  input  26  jump instr_index field
jal_i  input  1  current instruction links (jal/jalr); qualifies a RAS push
jr_take_i  input  1  jr/jalr taken
jr_target_i  input  ADDR_WIDTH  register-file source value for jr
jr_ra_i  input  1  jr source is $31; qualifies a RAS pop
exc_i  input  1  exception request
eret_i  input  1  return from exception
epc_i  input  ADDR_WIDTH  saved EPC
pc_o  output  ADDR_WIDTH  current PC (registered)
link_o  output  ADDR_WIDTH  pc_o + 4 (combinational)
ras_top_o  output  ADDR_WIDTH  RAS predicted return address
ras_valid_o  output  1  RAS non-empty
mispred_cnt_o  output  CNT_WIDTH  count of jr $ra mismatches

Behaviour:
- Single clock, clk. rst is synchronous and active-high.
- Reset values:
  - pc_o = RESET_PC.
  - RAS pointer = 0, RAS occupancy = 0, RAS entries = 0.
  - ras_valid_o = 0, ras_top_o = 0.
  - mispred_cnt_o = 0.
- rst has priority over every other input, including exc_i. Reset mid-stall or mid-jump discards all in-flight requests.
- Arithmetic: modulo 2^ADDR_WIDTH, no overflow flagging.
  - seq = pc_o + 4.
  - br_tgt = seq + (sign-extend(br_off_i) << 2).
  - j_tgt = {seq[ADDR_WIDTH-1:28], j_index_i, 2'b00}. When ADDR_WIDTH = 28 there is no upper field.
- Next-PC priority, highest first: exc_i → EXC_VECTOR; eret_i → epc_i; jr_take_i → jr_target_i; j_take_i → j_tgt; br_take_i → br_tgt; else seq.
- Latency: the selected target appears on pc_o one cycle after the request cycle. No prediction is applied to pc_o; ras_top_o is advisory only.
- Stall:
  - stall_i = 1 with exc_i = 0: pc_o holds; no RAS push/pop; counter holds.
  - exc_i = 1 overrides stall_i: the PC loads EXC_VECTOR.
- RAS push: condition is jal_i & (j_take_i | jr_take_i) & ~stall_i & ~exc_i.
  - Write seq at the pointer, then pointer = pointer + 1 (mod RAS_DEPTH).
  - Occupancy = min(occupancy + 1, RAS_DEPTH).
  - Full push overwrites the oldest entry (circular); occupancy stays RAS_DEPTH.
- RAS pop: condition is jr_take_i & jr_ra_i & ~jal_i & ~stall_i & ~exc_i.
  - Compare jr_target_i against ras_top_o. If they differ, or the RAS is empty, increment the mispredict counter.
  - If non-empty: pointer = pointer − 1, occupancy − 1.
  - Pop on empty: pointer and occupancy unchanged.
- jalr $31 (jal_i and jr_ra_i both set) is treated as a push only.
- ras_top_o = entry[pointer − 1] when occupancy > 0, else 0. ras_valid_o = (occupancy != 0).
- mispred_cnt_o saturates at all-ones; no wrap.
- eret_i does not touch the RAS.
- Multiple target requests in one cycle are legal; only the highest priority takes effect. RAS push/pop conditions are evaluated independently of the PC priority, except for exc_i suppression.

Test Plan:
- Reset: assert rst for 2 cycles with exc_i = 1 and j_take_i = 1 → pc_o = 0, ras_valid_o = 0, mispred_cnt_o = 0. Then release with no requests → pc_o steps 0, 4, 8, 12.
- Branch sign and wrap:
  - pc_o = 0x100, br_take_i, br_off_i = 0xFFFE → next pc_o = 0xFC.
  - pc_o = 0xFFFF_FFFC, no request → pc_o = 0x0.
- Jump and RAS prediction:
  - pc_o = 0x4000_0010, j_take_i + jal_i, j_index_i = 0x40 → pc_o = 0x4000_0100, ras_top_o = 0x4000_0014.
  - Later jr_take_i + jr_ra_i, jr_target_i = 0x4000_0014 → pc_o = 0x4000_0014, ras_valid_o = 0, mispred_cnt_o = 0.
- RAS overflow: five jal pushes with RAS_DEPTH = 4, links A..E → pops return E, D, C, B. The fifth pop is on empty: mispred_cnt_o increments, ras_valid_o stays 0.
- Priority and stall:
  - exc_i, eret_i, jr_take_i, br_take_i together while stall_i = 1 → pc_o = 0x180, no RAS change.
  - Next cycle stall_i alone → pc_o holds 0x180 for the whole stall.
- Mispredict saturation: CNT_WIDTH = 2, five mismatched jr $ra pops → mispred_cnt_o = 1, 2, 3, 3, 3.
